// File: rtl/audio_mode_mixer_if.sv
// Sample/control bundle between the filter bank, the mode mixer and the I2S transmitter.
interface audio_mode_mixer_if #(
    parameter int DATA_W   = 16,
    parameter int CHANNELS = 2
);
    logic [CHANNELS*DATA_W-1:0] src_a;
    logic [CHANNELS*DATA_W-1:0] src_b;
    logic [CHANNELS*DATA_W-1:0] src_c;
    logic [1:0]                 mode_sel;
    logic                       sample_stb;
    logic [CHANNELS*DATA_W-1:0] out_data;
    logic                       out_valid;
    logic                       busy;
    logic [1:0]                 mode_cur;

    modport master (
        output src_a, src_b, src_c, mode_sel,
        input  sample_stb, out_data, out_valid, busy, mode_cur
    );

    modport slave (
        input  src_a, src_b, src_c, mode_sel,
        output sample_stb, out_data, out_valid, busy, mode_cur
    );
endinterface

// File: rtl/audio_mode_mixer.sv
// Multi-channel raw/FIR/IIR output selector with LRCLK-derived frame strobe
// and a linear crossfade of 2^RAMP_LOG2 frames on every mode change.
module audio_mode_mixer #(
    parameter int DATA_W      = 16,
    parameter int CHANNELS    = 2,
    parameter int RAMP_LOG2   = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lrclk,
    audio_mode_mixer_if.slave  bus
);
    // product/sum width: sample * weight (weight <= 2^RAMP_LOG2) plus headroom
    localparam int PW = DATA_W + RAMP_LOG2 + 2;
    localparam logic [RAMP_LOG2-1:0] K_LAST = {RAMP_LOG2{1'b1}};
    localparam logic [RAMP_LOG2:0]   R_W    = {1'b1, {RAMP_LOG2{1'b0}}};

    typedef enum logic {IDLE, FADE} state_t;

    logic [SYNC_STAGES-1:0]           lr_sync;
    logic                             lr_dly;
    logic                             stb_q;
    state_t                           state;
    logic [RAMP_LOG2-1:0]             k;
    logic [1:0]                       mode_cur_q;
    logic [1:0]                       mode_tgt;
    logic [1:0]                       mode_dec;
    logic                             busy_q;
    logic                             valid_q;
    logic [CHANNELS-1:0][DATA_W-1:0]  mix;
    logic [CHANNELS-1:0][DATA_W-1:0]  out_q;
    logic [RAMP_LOG2:0]               w_new;
    logic [RAMP_LOG2:0]               w_old;
    logic signed [PW-1:0]             wn_x;
    logic signed [PW-1:0]             wo_x;

    // LRCLK synchroniser, one delay flop, and registered falling-edge strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lr_sync <= '0;
            lr_dly  <= 1'b0;
            stb_q   <= 1'b0;
        end else begin
            lr_sync <= {lr_sync[SYNC_STAGES-2:0], lrclk};
            lr_dly  <= lr_sync[SYNC_STAGES-1];
            stb_q   <= lr_dly & ~lr_sync[SYNC_STAGES-1];
        end
    end

    // encoding 3 is an alias for the raw source
    assign mode_dec = (bus.mode_sel == 2'd3) ? 2'd0 : bus.mode_sel;

    // k stays 0 in IDLE, so the same datapath yields pure src[mode_cur] there
    assign w_new = {1'b0, k};
    assign w_old = R_W - w_new;
    assign wn_x  = $signed({{(PW-RAMP_LOG2-1){1'b0}}, w_new});
    assign wo_x  = $signed({{(PW-RAMP_LOG2-1){1'b0}}, w_old});

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic signed [DATA_W-1:0] old_s;
        logic signed [DATA_W-1:0] new_s;
        logic signed [PW-1:0]     old_x;
        logic signed [PW-1:0]     new_x;
        logic signed [PW-1:0]     sum;

        // pick the committed and target sources for this channel
        always_comb begin
            case (mode_cur_q)
                2'd1:    old_s = $signed(bus.src_b[c*DATA_W +: DATA_W]);
                2'd2:    old_s = $signed(bus.src_c[c*DATA_W +: DATA_W]);
                default: old_s = $signed(bus.src_a[c*DATA_W +: DATA_W]);
            endcase
            case (mode_tgt)
                2'd1:    new_s = $signed(bus.src_b[c*DATA_W +: DATA_W]);
                2'd2:    new_s = $signed(bus.src_c[c*DATA_W +: DATA_W]);
                default: new_s = $signed(bus.src_a[c*DATA_W +: DATA_W]);
            endcase
        end

        assign old_x  = $signed({{(PW-DATA_W){old_s[DATA_W-1]}}, old_s});
        assign new_x  = $signed({{(PW-DATA_W){new_s[DATA_W-1]}}, new_s});
        assign sum    = old_x * wo_x + new_x * wn_x;
        // weights sum to R, so the floored quotient always fits DATA_W
        assign mix[c] = DATA_W'(sum >>> RAMP_LOG2);
    end

    // mode/fade FSM with registered sample output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            k          <= '0;
            mode_cur_q <= 2'd0;
            mode_tgt   <= 2'd0;
            busy_q     <= 1'b0;
            out_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (stb_q) begin
                out_q   <= mix;
                valid_q <= 1'b1;
                case (state)
                    IDLE: begin
                        if (mode_dec != mode_cur_q) begin
                            mode_tgt <= mode_dec;
                            k        <= {{(RAMP_LOG2-1){1'b0}}, 1'b1};
                            busy_q   <= 1'b1;
                            state    <= FADE;
                        end
                    end
                    FADE: begin
                        if (k == K_LAST) begin
                            mode_cur_q <= mode_tgt;
                            k          <= '0;
                            busy_q     <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.sample_stb = stb_q;
    assign bus.out_data   = out_q;
    assign bus.out_valid  = valid_q;
    assign bus.busy       = busy_q;
    assign bus.mode_cur   = mode_cur_q;
endmodule

// File: doc/audio_mode_mixer.md
# audio_mode_mixer

Parametrised, multi-channel successor to the fixed mono raw/FIR/IIR output mux. It sits between the filter bank (raw, FIR, IIR sources) and the I2S transmitter. It derives the per-frame sample strobe from LRCLK in the system clock domain. Mode changes are applied as a linear crossfade over a fixed number of frames instead of an abrupt switch, so the DAC output does not click.

## Interface
- `DATA_W`, 16: signed sample width per channel.
- `CHANNELS`, 2: number of parallel channels. All channels share mode and fade state.
- `RAMP_LOG2`, 6: crossfade length is R = 2^RAMP_LOG2 frames.
- `SYNC_STAGES`, 2: LRCLK synchroniser depth, minimum 2.

- `clk` in 1: system clock (50 MHz). Single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `lrclk` in 1: I2S LRCLK, asynchronous to `clk`.
- `src_a` in CHANNELS*DATA_W: raw/bypass samples. Channel c occupies bits [c*DATA_W +: DATA_W].
- `src_b` in CHANNELS*DATA_W: FIR samples, same packing.
- `src_c` in CHANNELS*DATA_W: IIR samples, same packing.
- `mode_sel` in 2: requested mode. 0 = A, 1 = B, 2 = C, 3 = treated as A.
- `sample_stb` out 1: one-cycle pulse per LRCLK falling edge.
- `out_data` out CHANNELS*DATA_W: mixed samples, held between updates.
- `out_valid` out 1: one-cycle pulse when `out_data` updates.
- `busy` out 1: crossfade in progress.
- `mode_cur` out 2: currently committed mode (0..2).

## Operation
- **LRCLK strobe**
  - `lrclk` passes through a SYNC_STAGES flop chain, followed by one delay flop.
  - `sample_stb` = delayed & ~synced, registered.
  - All sync flops reset to 0. A high `lrclk` at reset release therefore produces no strobe.
- **Mode decode:** `mode_sel` is sampled only on `sample_stb` cycles; 3 maps to 0.
- **FSM states**
  - **IDLE**
    - On `sample_stb`, output = src[mode_cur].
    - If decoded `mode_sel` ≠ `mode_cur`: latch `mode_tgt`, set k = 1, set `busy`, go to FADE.
    - The detecting frame outputs pure old data.
  - **FADE**
    - On `sample_stb`, per channel: out = (old·(R−k) + new·k) >>> RAMP_LOG2, where old = src[mode_cur] and new = src[mode_tgt].
    - If k == R−1: `mode_cur` ← `mode_tgt`, clear `busy`, go to IDLE.
    - Otherwise k ← k+1.
    - `mode_sel` is ignored throughout FADE. It is re-evaluated at the first IDLE strobe.
- **Arithmetic**
  - Samples are signed DATA_W. Weights are unsigned RAMP_LOG2+1 bits.
  - Each product and the sum use DATA_W+RAMP_LOG2+2 signed bits.
  - Arithmetic right shift (floor toward −∞); no rounding.
  - Weights sum to R, so the result always fits DATA_W and no saturation is needed.
- **Channels:** all channels are computed in parallel with identical weights. No cross-channel interaction.
- **Reset mid-fade:** FADE is abandoned; `mode_cur` = 0 and the FSM is in IDLE.

## Timing
- `sample_stb` rises SYNC_STAGES+1 `clk` cycles after the LRCLK falling edge (±1 for sync uncertainty).
- Sources are sampled in the `sample_stb` cycle. `out_data` and `out_valid` update on the next edge (latency 1).
- `busy` rises on the edge ending detection strobe n and falls on the edge ending strobe n+R−1.
- The first pure-new output is at strobe n+R.
- Reset values: `sample_stb` 0, `out_valid` 0, `out_data` 0, `busy` 0, `mode_cur` 0, FSM IDLE, k 0.
- Strobes are at most one per LRCLK period. Back-to-back `clk` strobes cannot occur; no queuing is required.

## Test plan
- **Reset:** assert `rst` with `lrclk` = 1, release, hold `lrclk` high for 10 cycles → `sample_stb`, `out_valid`, `busy` stay 0; `out_data` = 0; `mode_cur` = 0.
- **Bypass:** toggle `lrclk` at 48 kHz with `mode_sel` = 0, ch0 src_a = 0x1234, ch1 src_a = 0xFEDC → one `sample_stb` per falling edge, 3 cycles after the edge (SYNC_STAGES = 2). `out_valid` follows 1 cycle later with `out_data` = {0xFEDC, 0x1234}.
- **Crossfade** (defaults, all channels src_a = +1000, src_b = −1000), `mode_sel` 0→1:
  - Detection frame → 1000.
  - k = 1 → 968; k = 32 → 0; k = 63 → −969.
  - Next frame → −1000 with `mode_cur` = 1.
  - `busy` is high for exactly 63 frames.
- **Mode change during fade:** switch 0→1, then set `mode_sel` = 2 at k = 10 → the fade to 1 completes unchanged. The next IDLE strobe starts a 1→2 fade.
- **Mode 3 and no-op:** with `mode_cur` = 0, set `mode_sel` = 3 → no fade, `busy` stays 0, output = src_a.
- **Reset mid-fade:** assert `rst` at k = 20 of a 0→2 fade → all outputs return to reset values immediately. After release with `mode_sel` = 2, a fresh 0→2 fade starts from k = 0 at the first strobe.
